// File: rtl/hsid_vctr_op_if.sv
`default_nettype none
// ============================================================================
// hsid_vctr_op_if : element streams of hsid_vctr_op (operand in, result out)
// Revision 1.0
// ============================================================================
interface hsid_vctr_op_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                    data_in_valid;
    logic                    data_in_ready;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    data_out_valid;
    logic                    data_out_ready;
    logic [2*DATA_WIDTH-1:0] data_out;

    modport master (
        output data_in_valid, data_in, data_out_ready,
        input  data_in_ready, data_out_valid, data_out
    );

    modport slave (
        input  data_in_valid, data_in, data_out_ready,
        output data_in_ready, data_out_valid, data_out
    );
endinterface
`default_nettype wire

// File: rtl/hsid_vctr_op.sv
`default_nettype none
// ============================================================================
// hsid_vctr_op : loads vectors A then B, computes element-wise ADD/SUB/ABS/SQ
//                difference, streams results. Option: HSID_VCTR_OP_ACCUM_EN.
// Revision 1.0
// ============================================================================
module hsid_vctr_op #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LEN    = 8,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN) + 1
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   start,
    input  wire [LEN_WIDTH-1:0]   vctr_len,
    input  wire [1:0]             mode,
    hsid_vctr_op_if.slave         bus,
    output logic                  idle,
    output logic                  done,
    output logic                  error
`ifdef HSID_VCTR_OP_ACCUM_EN
    ,
    output logic [2*DATA_WIDTH+LEN_WIDTH-1:0] acc_out
`endif
);

    localparam int                 c_idx_w   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_WIDTH-1:0] c_max_len = LEN_WIDTH'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [1:0]              mode_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic [LEN_WIDTH-1:0]    rd_q;
    logic                    s1_vld_q;
    logic [c_idx_w-1:0]      s1_idx_q;
    logic [DATA_WIDTH-1:0]   s1_a_q;
    logic [DATA_WIDTH-1:0]   s1_b_q;
    logic                    in_rdy_q;
    logic                    out_vld_q;
    logic                    idle_q;
    logic                    done_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   a_mem [MAX_LEN];
    logic [DATA_WIDTH-1:0]   b_mem [MAX_LEN];
    logic [2*DATA_WIDTH-1:0] r_mem [MAX_LEN];

    logic                    w_len_ok;
    logic                    w_in_fire;
    logic [LEN_WIDTH-1:0]    w_last;
    logic [c_idx_w-1:0]      w_idx;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_absd;
    logic [2*DATA_WIDTH-1:0] w_res;

    assign w_len_ok  = (vctr_len != '0) && (vctr_len <= c_max_len);
    assign w_in_fire = bus.data_in_valid && in_rdy_q;
    assign w_last    = len_q - 1'b1;
    assign w_idx     = cnt_q[c_idx_w-1:0];

    // Stage-2 arithmetic on the registered stage-1 operands
    assign w_diff = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    assign w_absd = (s1_a_q >= s1_b_q) ? (s1_a_q - s1_b_q) : (s1_b_q - s1_a_q);

    always_comb begin
        w_res = '0;
        case (mode_q)
            2'd0:    w_res = (2*DATA_WIDTH)'({1'b0, s1_a_q} + {1'b0, s1_b_q});
            2'd1:    w_res = (2*DATA_WIDTH)'($signed(w_diff));
            2'd2:    w_res = (2*DATA_WIDTH)'(w_absd);
            default: w_res = (2*DATA_WIDTH)'(w_absd) * (2*DATA_WIDTH)'(w_absd);
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_in_fire && (state_q == S_LOAD_A)) a_mem[w_idx] <= bus.data_in;
        if (w_in_fire && (state_q == S_LOAD_B)) b_mem[w_idx] <= bus.data_in;
        if (s1_vld_q)                           r_mem[s1_idx_q] <= w_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            mode_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            s1_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            len_q    <= vctr_len;
                            mode_q   <= mode;
                            cnt_q    <= '0;
                            rd_q     <= '0;
                            in_rdy_q <= 1'b1;
                            idle_q   <= 1'b0;
                            state_q  <= S_LOAD_A;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD_A: begin
                    if (w_in_fire) begin
                        if (cnt_q == w_last) begin
                            cnt_q   <= '0;
                            state_q <= S_LOAD_B;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_in_fire) begin
                        if (cnt_q == w_last) begin
                            cnt_q    <= '0;
                            in_rdy_q <= 1'b0;
                            state_q  <= S_COMPUTE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    // len issue cycles plus one cycle for the last stage-2 write
                    if (cnt_q < len_q) begin
                        s1_vld_q <= 1'b1;
                        s1_idx_q <= w_idx;
                        s1_a_q   <= a_mem[w_idx];
                        s1_b_q   <= b_mem[w_idx];
                        cnt_q    <= cnt_q + 1'b1;
                    end else begin
                        cnt_q     <= '0;
                        rd_q      <= '0;
                        out_vld_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.data_out_ready) begin
                        if (rd_q == w_last) begin
                            out_vld_q <= 1'b0;
                            done_q    <= 1'b1;
                            idle_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            rd_q <= rd_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    in_rdy_q  <= 1'b0;
                    out_vld_q <= 1'b0;
                    idle_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_in_ready  = in_rdy_q;
    assign bus.data_out_valid = out_vld_q;
    assign bus.data_out       = out_vld_q ? r_mem[rd_q[c_idx_w-1:0]] : '0;
    assign idle               = idle_q;
    assign done               = done_q;
    assign error              = err_q;

`ifdef HSID_VCTR_OP_ACCUM_EN
    localparam int c_acc_w = 2*DATA_WIDTH + LEN_WIDTH;

    logic [c_acc_w-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if ((state_q == S_IDLE) && start && w_len_ok) begin
            acc_q <= '0;
        end else if (s1_vld_q) begin
            acc_q <= acc_q + ((mode_q == 2'd1) ? c_acc_w'($signed(w_res)) : c_acc_w'(w_res));
        end
    end

    assign acc_out = acc_q;
`endif

endmodule
`default_nettype wire
